// File: rtl/bitcount_ctrl_if.sv
// Control/status bundle between the bit-count controller and its datapath.
// The datapath side owns A; the controller side owns the strobes and status.
interface bitcount_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic             load_A;
  logic             right_shiftA;
  logic             incr_result;
  logic             done;
  logic             busy;
  logic             err;

  modport master (output start, A,
                  input  load_A, right_shiftA, incr_result, done, busy, err);
  modport slave  (input  start, A,
                  output load_A, right_shiftA, incr_result, done, busy, err);
endinterface

// File: rtl/bitcount_ctrl.sv
// Bit-count controller: synchronises start, then walks A right one bit per
// cycle, pulsing incr_result on each set LSB until A empties or WIDTH shifts.
module bitcount_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  bitcount_ctrl_if.slave  bus
);
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [IW-1:0] r_iter;
  logic          r_err;
  logic          w_start_s;
  logic          w_a_nz;
  logic          w_iter_lim;

  // Start comes from a button/switch, so it only enters logic via two flops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], bus.start};
  end

  assign w_start_s  = r_sync[1];
  assign w_a_nz     = |bus.A;
  assign w_iter_lim = (r_iter == IW'(WIDTH));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_iter <= '0;
          if (w_start_s) begin
            r_state <= S_SHIFT;
            r_err   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!w_a_nz) begin
            r_state <= S_DONE;
          end else if (w_iter_lim) begin
            // A never drained within WIDTH shifts: the datapath is stuck.
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_iter <= r_iter + IW'(1);
          end
        end
        S_DONE: begin
          if (!w_start_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the current state so the datapath acts on them
  // at the same edge that advances the FSM.
  always_comb begin
    bus.load_A       = 1'b0;
    bus.right_shiftA = 1'b0;
    bus.incr_result  = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    unique case (r_state)
      S_IDLE:  bus.load_A = 1'b1;
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (w_a_nz && !w_iter_lim) begin
          bus.right_shiftA = 1'b1;
          bus.incr_result  = bus.A[0];
        end
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.err = r_err;
endmodule

// File: doc/bitcount_ctrl.md
BITCOUNT_CTRL -- requirements
Module: bitcount_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the operand register A in the bit-count datapath.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  asynchronous request from a push-button or switch; held high to run, dropped low to re-arm.
REQ-005 A  input  WIDTH  current value of the datapath operand register.
REQ-006 load_A  output  1  loads the switch value into A and clears result in the datapath.
REQ-007 right_shiftA  output  1  shifts A right by one in the datapath.
REQ-008 incr_result  output  1  increments the datapath result counter.
REQ-009 done  output  1  count complete; result is valid.
REQ-010 busy  output  1  counting in progress.
REQ-011 err  output  1  iteration limit exceeded while A was still nonzero.

Function
REQ-012 The block SHALL pass start through a two-flop synchronizer (start_s) before any use.
REQ-013 The FSM SHALL have exactly three states: S_IDLE, S_SHIFT and S_DONE, held in a registered state variable.
REQ-014 The outputs SHALL be combinational functions of the state register, A and the iteration counter, so the datapath acts on them at the same clk edge as the state update.
REQ-015 S_IDLE: load_A=1, right_shiftA=0, incr_result=0, busy=0, done=0.
REQ-016 S_IDLE: if start_s=1, the next state SHALL be S_SHIFT; otherwise the FSM SHALL stay in S_IDLE.
REQ-017 S_SHIFT with A!=0 and iter<WIDTH: right_shiftA=1, incr_result=A[0], busy=1, and iter SHALL increment; the FSM SHALL stay in S_SHIFT.
REQ-018 S_SHIFT with A==0: the next state SHALL be S_DONE, with no shift and no increment; busy=1 in this cycle.
REQ-019 S_SHIFT with A!=0 and iter==WIDTH: err SHALL be set, the next state SHALL be S_DONE, and there SHALL be no shift and no increment.
REQ-020 S_DONE: done=1, load_A=0, right_shiftA=0, incr_result=0, busy=0.
REQ-021 S_DONE: the FSM SHALL stay in S_DONE while start_s=1 and SHALL return to S_IDLE when start_s=0.
REQ-022 iter SHALL be a clog2(WIDTH+1)-bit counter, cleared in S_IDLE, and SHALL never wrap.
REQ-023 err SHALL be sticky through S_DONE and SHALL be cleared on the S_IDLE->S_SHIFT transition.
REQ-024 Latency: state SHALL enter S_SHIFT at the 3rd rising edge at which raw start is high (2 sync flops plus the state register).
REQ-025 Total count latency from S_SHIFT entry to done=1 SHALL be (index of the highest set bit of A + 2) cycles, or 1 cycle when A==0.
REQ-026 A start glitch shorter than one clk period that never reaches start_s SHALL have no effect.
REQ-027 Deasserting start during S_SHIFT SHALL NOT abort the count; S_DONE is entered normally and then exits immediately to S_IDLE.
REQ-028 The controller SHALL never assert load_A and right_shiftA in the same cycle.

Reset
REQ-029 While reset=1, regardless of clk, the block SHALL hold state=S_IDLE, both sync flops at 0, iter=0 and err=0.
REQ-030 The outputs under reset SHALL be: load_A=1, right_shiftA=0, incr_result=0, done=0, busy=0, err=0.
REQ-031 Reset asserted mid-S_SHIFT SHALL abandon the count immediately, with no further shift or increment pulses.

Verification
REQ-032 Scenario, 0xDB count: A=8'hDB with start held high -> 8 right_shiftA cycles and 6 incr_result pulses (pattern 1,1,0,1,1,0,1,1), then done=1 and err=0.
REQ-033 Scenario, zero operand: A=8'h00 with start high -> exactly 1 S_SHIFT cycle with no pulses, then done=1 and 0 increments.
REQ-034 Scenario, top bit only: A=8'h80 -> 8 shift cycles, 1 incr_result pulse on the 8th, then done.
REQ-035 Scenario, stuck operand: A forced to 8'hFF (datapath ignores shifts) -> 8 shifts, then err=1 and done=1; err clears on the next start.
REQ-036 Scenario, reset mid-count: reset pulsed during the 3rd shift cycle of 0xDB -> immediately S_IDLE with load_A=1, and no further pulses after reset releases while start is low.
REQ-037 Scenario, start release and glitch: start dropped in S_DONE -> S_IDLE on the 3rd edge; a 1-cycle start glitch in S_IDLE -> a single S_SHIFT entry only if it was captured by the sync flop.
